// File: rtl/musa_control_unit.sv
// musa_control_unit
// -----------------
// Main decoder and sequencer for the MUSA core. An instruction is accepted on
// a rising edge where instr_valid and instr_ready are both high. The datapath
// controls it decodes to appear from an output register one cycle later and
// last for one cycle only. MULT/DIV hold the front end for the multi-cycle
// unit's occupancy. HALT parks the core until reset.
//
// Parameters
//   DATA_WIDTH  instruction width (opcode [31:26], funct [5:0], mask [3:0])
//   MULDIV_LAT  total occupancy cycles of MULT/DIV, legal range 2..15
//
// Ports
//   clk, rst         processor clock, asynchronous active-high reset
//   instr_valid      fetch presents an instruction
//   instruction      instruction word
//   flags            ALU status flags used by BRFL
//   stall_in         downstream hold request
//   instr_ready      instruction accepted this cycle when high with instr_valid
//   reg_dst .. flag_we  registered datapath controls (one-cycle pulses)
//   halted           core stopped by HALT
//   illegal          one-cycle pulse on an undecodable opcode
//
// Configuration
//   MUSA_STACK_EN    when defined, CALL/RET drive push/pop. When undefined,
//                    push/pop stay 0 and CALL/RET decode as illegal.

module musa_control_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int MULDIV_LAT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_valid,
  input  logic [DATA_WIDTH-1:0] instruction,
  input  logic [3:0]            flags,
  input  logic                  stall_in,
  output logic                  instr_ready,
  output logic                  reg_dst,
  output logic                  mem_read,
  output logic                  mem_to_reg,
  output logic                  mem_write,
  output logic                  reg_write,
  output logic                  data_a_s,
  output logic                  data_b_s,
  output logic                  pc_src,
  output logic                  pop,
  output logic                  push,
  output logic                  flag_we,
  output logic                  halted,
  output logic                  illegal
);

  // Opcode and funct encodings shared with the assembler
  localparam logic [5:0] OP_R_TYPE = 6'h00;
  localparam logic [5:0] OP_ADDI   = 6'h01;
  localparam logic [5:0] OP_SUBI   = 6'h02;
  localparam logic [5:0] OP_ANDI   = 6'h03;
  localparam logic [5:0] OP_ORI    = 6'h04;
  localparam logic [5:0] OP_LW     = 6'h05;
  localparam logic [5:0] OP_SW     = 6'h06;
  localparam logic [5:0] OP_CMP    = 6'h07;
  localparam logic [5:0] OP_JPC    = 6'h08;
  localparam logic [5:0] OP_JR     = 6'h09;
  localparam logic [5:0] OP_CALL   = 6'h0A;
  localparam logic [5:0] OP_RET    = 6'h0B;
  localparam logic [5:0] OP_BRFL   = 6'h0C;
  localparam logic [5:0] OP_HALT   = 6'h3F;

  localparam logic [5:0] FN_MULT   = 6'h18;
  localparam logic [5:0] FN_DIV    = 6'h1A;

  // The accepting cycle is the first occupancy cycle, so the front end
  // stays blocked for MULDIV_LAT-1 further cycles. The counter therefore
  // runs from MULDIV_LAT-2 down to 0 inclusive.
  localparam logic [3:0] CNT_LOAD  = 4'(MULDIV_LAT - 2);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MULDIV,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic reg_dst;
    logic mem_read;
    logic mem_to_reg;
    logic mem_write;
    logic reg_write;
    logic data_a_s;
    logic data_b_s;
    logic pc_src;
    logic pop;
    logic push;
    logic flag_we;
  } ctrl_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       illegal_q, illegal_d;
  logic       halted_q, halted_d;

  ctrl_t      ctrl_dec;
  logic       illegal_dec;
  logic       muldiv_dec;
  logic       halt_dec;
  logic       accept;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_instr_bits;

  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];

  // Only a few fields are decoded. The rest of the word is folded here.
  assign unused_instr_bits = ^instruction;

  // Ready is held low during reset so fetch cannot see a spurious accept.
  assign instr_ready = ~rst & (state_q == ST_RUN) & ~stall_in;
  assign accept      = instr_valid & instr_ready;

  // Combinational decode of the presented instruction. The result is used
  // only on the acceptance edge. BRFL samples flags in that same cycle.
  always_comb begin
    ctrl_dec    = '0;
    illegal_dec = 1'b0;
    muldiv_dec  = 1'b0;
    halt_dec    = 1'b0;
    case (opcode)
      OP_LW: begin
        ctrl_dec.mem_read   = 1'b1;
        ctrl_dec.mem_to_reg = 1'b1;
        ctrl_dec.reg_write  = 1'b1;
        ctrl_dec.data_b_s   = 1'b1;
      end
      OP_SW: begin
        ctrl_dec.mem_write  = 1'b1;
        ctrl_dec.data_b_s   = 1'b1;
      end
      OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: begin
        ctrl_dec.reg_write  = 1'b1;
        ctrl_dec.data_b_s   = 1'b1;
      end
      OP_R_TYPE: begin
        ctrl_dec.reg_dst    = 1'b1;
        ctrl_dec.reg_write  = 1'b1;
        muldiv_dec          = (funct == FN_MULT) || (funct == FN_DIV);
      end
      OP_CMP:  ctrl_dec.flag_we = 1'b1;
      OP_JPC:  ctrl_dec.pc_src  = 1'b1;
      OP_JR: begin
        ctrl_dec.pc_src     = 1'b1;
        ctrl_dec.data_a_s   = 1'b1;
      end
`ifdef MUSA_STACK_EN
      OP_CALL: begin
        ctrl_dec.pc_src     = 1'b1;
        ctrl_dec.data_a_s   = 1'b1;
        ctrl_dec.push       = 1'b1;
      end
      OP_RET: begin
        ctrl_dec.pc_src     = 1'b1;
        ctrl_dec.pop        = 1'b1;
      end
`else
      // Without the stack, push/pop are never decoded, so their output
      // flops are constant 0. CALL/RET fall through to illegal.
`endif
      OP_BRFL: ctrl_dec.pc_src = |(flags & instruction[3:0]);
      OP_HALT: halt_dec = 1'b1;
      default: illegal_dec = 1'b1;
    endcase
  end

  // Next-state logic. Controls and illegal default to 0 so each one is a
  // single-cycle pulse after its acceptance. Nothing is accepted outside RUN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = '0;
    illegal_d = 1'b0;
    halted_d  = halted_q;
    case (state_q)
      ST_RUN: begin
        if (accept) begin
          ctrl_d    = ctrl_dec;
          illegal_d = illegal_dec;
          if (muldiv_dec) begin
            state_d = ST_MULDIV;
            cnt_d   = CNT_LOAD;
          end else if (halt_dec) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end
        end
      end
      ST_MULDIV: begin
        // Downstream stalls freeze the occupancy countdown.
        if (!stall_in) begin
          if (cnt_q == 4'd0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      ST_HALT: begin
        halted_d = 1'b1;
      end
      default: begin
        state_d  = ST_RUN;
        halted_d = 1'b0;
      end
    endcase
  end

  // State register. Reset aborts MULDIV or HALT at once and clears any
  // pending control pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      cnt_q     <= 4'd0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
      halted_q  <= halted_d;
    end
  end

  assign reg_dst    = ctrl_q.reg_dst;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign mem_write  = ctrl_q.mem_write;
  assign reg_write  = ctrl_q.reg_write;
  assign data_a_s   = ctrl_q.data_a_s;
  assign data_b_s   = ctrl_q.data_b_s;
  assign pc_src     = ctrl_q.pc_src;
  assign pop        = ctrl_q.pop;
  assign push       = ctrl_q.push;
  assign flag_we    = ctrl_q.flag_we;
  assign illegal    = illegal_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_musa_control_unit.sv
// tb_musa_control_unit
// --------------------
// Directed bench for musa_control_unit using the default parameters
// (DATA_WIDTH=32, MULDIV_LAT=4). Each step drives one cycle of stimulus,
// checks instr_ready right away, and queues the controls expected after the
// next rising edge. Those controls are checked at the following step.

module tb_musa_control_unit;

  localparam logic [5:0] OP_R_TYPE = 6'h00;
  localparam logic [5:0] OP_ADDI   = 6'h01;
  localparam logic [5:0] OP_ORI    = 6'h04;
  localparam logic [5:0] OP_LW     = 6'h05;
  localparam logic [5:0] OP_SW     = 6'h06;
  localparam logic [5:0] OP_CMP    = 6'h07;
  localparam logic [5:0] OP_JPC    = 6'h08;
  localparam logic [5:0] OP_JR     = 6'h09;
  localparam logic [5:0] OP_CALL   = 6'h0A;
  localparam logic [5:0] OP_RET    = 6'h0B;
  localparam logic [5:0] OP_BRFL   = 6'h0C;
  localparam logic [5:0] OP_HALT   = 6'h3F;
  localparam logic [5:0] OP_BAD    = 6'h20;
  localparam logic [5:0] FN_ADD    = 6'h20;
  localparam logic [5:0] FN_MULT   = 6'h18;
  localparam logic [5:0] FN_DIV    = 6'h1A;

  // Control vector order:
  // {reg_dst, mem_read, mem_to_reg, mem_write, reg_write,
  //  data_a_s, data_b_s, pc_src, pop, push, flag_we}
  localparam logic [10:0] C_RD   = 11'h400;
  localparam logic [10:0] C_MR   = 11'h200;
  localparam logic [10:0] C_MTR  = 11'h100;
  localparam logic [10:0] C_MW   = 11'h080;
  localparam logic [10:0] C_RW   = 11'h040;
  localparam logic [10:0] C_DA   = 11'h020;
  localparam logic [10:0] C_DB   = 11'h010;
  localparam logic [10:0] C_PC   = 11'h008;
  localparam logic [10:0] C_POP  = 11'h004;
  localparam logic [10:0] C_PUSH = 11'h002;
  localparam logic [10:0] C_FW   = 11'h001;
  localparam logic [10:0] C_NONE = 11'h000;

  typedef struct {
    string       name;
    logic [10:0] ctrl;
    logic        illegal;
    logic        halted;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [3:0]  flags;
  logic        stall_in;
  logic        instr_ready;
  logic        reg_dst, mem_read, mem_to_reg, mem_write, reg_write;
  logic        data_a_s, data_b_s, pc_src, pop, push, flag_we;
  logic        halted;
  logic        illegal;

  int   testsRun;
  int   testsFailed;
  exp_t scoreboard[$];

  musa_control_unit dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .flags       (flags),
    .stall_in    (stall_in),
    .instr_ready (instr_ready),
    .reg_dst     (reg_dst),
    .mem_read    (mem_read),
    .mem_to_reg  (mem_to_reg),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .data_a_s    (data_a_s),
    .data_b_s    (data_b_s),
    .pc_src      (pc_src),
    .pop         (pop),
    .push        (push),
    .flag_we     (flag_we),
    .halted      (halted),
    .illegal     (illegal)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mkInstr(input logic [5:0] op, input logic [5:0] low);
    return {op, 20'h0, low};
  endfunction

  function automatic logic [10:0] observedCtrl();
    return {reg_dst, mem_read, mem_to_reg, mem_write, reg_write,
            data_a_s, data_b_s, pc_src, pop, push, flag_we};
  endfunction

  task automatic checkEq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pops the expectation queued by the previous step and compares it with
  // the registered outputs.
  task automatic checkOutput();
    exp_t e;
    if (scoreboard.size() == 0) begin
      testsRun++;
      testsFailed++;
      $error("[TB] FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = scoreboard.pop_front();
      checkEq({e.name, " ctrl"},    {5'b0, observedCtrl()}, {5'b0, e.ctrl});
      checkEq({e.name, " illegal"}, {15'b0, illegal},       {15'b0, e.illegal});
      checkEq({e.name, " halted"},  {15'b0, halted},        {15'b0, e.halted});
    end
  endtask

  task automatic pushExp(input string name, input logic [10:0] c, input logic il, input logic h);
    exp_t e;
    e.name    = name;
    e.ctrl    = c;
    e.illegal = il;
    e.halted  = h;
    scoreboard.push_back(e);
  endtask

  // One cycle of stimulus. Drive on the falling edge, check ready once the
  // combinational path settles, then queue the post-edge expectation.
  task automatic applyStimulus(input string name, input logic v, input logic [31:0] ins,
                               input logic [3:0] fl, input logic st, input logic expReady,
                               input logic [10:0] expCtrl, input logic expIll, input logic expHalt);
    @(negedge clk);
    checkOutput();
    instr_valid = v;
    instruction = ins;
    flags       = fl;
    stall_in    = st;
    #1;
    checkEq({name, " ready"}, {15'b0, instr_ready}, {15'b0, expReady});
    pushExp(name, expCtrl, expIll, expHalt);
  endtask

  task automatic idle(input string name);
    applyStimulus(name, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, C_NONE, 1'b0, 1'b0);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst         = 1'b1;
    instr_valid = 1'b0;
    instruction = 32'h0;
    flags       = 4'h0;
    stall_in    = 1'b0;

    // Reset state: everything cleared, and ready held low even with no stall
    repeat (2) @(negedge clk);
    checkEq("reset ctrl",    {5'b0, observedCtrl()}, 16'h0);
    checkEq("reset illegal", {15'b0, illegal},       16'h0);
    checkEq("reset halted",  {15'b0, halted},        16'h0);
    checkEq("reset ready",   {15'b0, instr_ready},   16'h0);
    rst = 1'b0;
    #1;
    checkEq("post_reset ready", {15'b0, instr_ready}, 16'h1);
    pushExp("post_reset", C_NONE, 1'b0, 1'b0);

    // Single-cycle decodes, each followed by an idle to confirm one-cycle pulses
    applyStimulus("lw", 1'b1, mkInstr(OP_LW, 6'h0), 4'h0, 1'b0, 1'b1, C_MR | C_MTR | C_RW | C_DB, 1'b0, 1'b0);
    idle("lw_after");
    applyStimulus("sw", 1'b1, mkInstr(OP_SW, 6'h0), 4'h0, 1'b0, 1'b1, C_MW | C_DB, 1'b0, 1'b0);
    applyStimulus("addi", 1'b1, mkInstr(OP_ADDI, 6'h0), 4'h0, 1'b0, 1'b1, C_RW | C_DB, 1'b0, 1'b0);
    applyStimulus("ori", 1'b1, mkInstr(OP_ORI, 6'h0), 4'h0, 1'b0, 1'b1, C_RW | C_DB, 1'b0, 1'b0);
    applyStimulus("add", 1'b1, mkInstr(OP_R_TYPE, FN_ADD), 4'h0, 1'b0, 1'b1, C_RD | C_RW, 1'b0, 1'b0);
    applyStimulus("cmp", 1'b1, mkInstr(OP_CMP, 6'h0), 4'h0, 1'b0, 1'b1, C_FW, 1'b0, 1'b0);
    applyStimulus("jpc", 1'b1, mkInstr(OP_JPC, 6'h0), 4'h0, 1'b0, 1'b1, C_PC, 1'b0, 1'b0);
    applyStimulus("jr", 1'b1, mkInstr(OP_JR, 6'h0), 4'h0, 1'b0, 1'b1, C_PC | C_DA, 1'b0, 1'b0);

    // BRFL: taken when any masked flag is set
    applyStimulus("brfl_taken", 1'b1, mkInstr(OP_BRFL, 6'h02), 4'b0010, 1'b0, 1'b1, C_PC, 1'b0, 1'b0);
    applyStimulus("brfl_not", 1'b1, mkInstr(OP_BRFL, 6'h02), 4'b0101, 1'b0, 1'b1, C_NONE, 1'b0, 1'b0);

    // CALL/RET depend on the stack build option
`ifdef MUSA_STACK_EN
    applyStimulus("call", 1'b1, mkInstr(OP_CALL, 6'h0), 4'h0, 1'b0, 1'b1, C_PC | C_DA | C_PUSH, 1'b0, 1'b0);
    applyStimulus("ret", 1'b1, mkInstr(OP_RET, 6'h0), 4'h0, 1'b0, 1'b1, C_PC | C_POP, 1'b0, 1'b0);
`else
    applyStimulus("call", 1'b1, mkInstr(OP_CALL, 6'h0), 4'h0, 1'b0, 1'b1, C_NONE, 1'b1, 1'b0);
    applyStimulus("ret", 1'b1, mkInstr(OP_RET, 6'h0), 4'h0, 1'b0, 1'b1, C_NONE, 1'b1, 1'b0);
`endif

    // Unknown opcode: a one-cycle illegal pulse, and the core keeps running
    applyStimulus("bad_op", 1'b1, mkInstr(OP_BAD, 6'h0), 4'h0, 1'b0, 1'b1, C_NONE, 1'b1, 1'b0);
    idle("bad_op_after");

    // MULT: ready low for cycles 1-3, next instruction accepted at cycle 4
    applyStimulus("mult", 1'b1, mkInstr(OP_R_TYPE, FN_MULT), 4'h0, 1'b0, 1'b1, C_RD | C_RW, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++)
      applyStimulus($sformatf("mult_busy%0d", i), 1'b1, mkInstr(OP_LW, 6'h0), 4'h0, 1'b0, 1'b0, C_NONE, 1'b0, 1'b0);
    applyStimulus("mult_next", 1'b1, mkInstr(OP_LW, 6'h0), 4'h0, 1'b0, 1'b1, C_MR | C_MTR | C_RW | C_DB, 1'b0, 1'b0);

    // DIV with a 3-cycle stall in MULDIV: ready returns at cycle 7
    applyStimulus("div", 1'b1, mkInstr(OP_R_TYPE, FN_DIV), 4'h0, 1'b0, 1'b1, C_RD | C_RW, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++)
      applyStimulus($sformatf("div_stall%0d", i), 1'b1, mkInstr(OP_SW, 6'h0), 4'h0, 1'b1, 1'b0, C_NONE, 1'b0, 1'b0);
    for (int i = 4; i <= 6; i++)
      applyStimulus($sformatf("div_busy%0d", i), 1'b1, mkInstr(OP_SW, 6'h0), 4'h0, 1'b0, 1'b0, C_NONE, 1'b0, 1'b0);
    applyStimulus("div_next", 1'b1, mkInstr(OP_SW, 6'h0), 4'h0, 1'b0, 1'b1, C_MW | C_DB, 1'b0, 1'b0);

    // Stall in RUN blocks acceptance, and the outputs go quiet
    applyStimulus("run_stall", 1'b1, mkInstr(OP_LW, 6'h0), 4'h0, 1'b1, 1'b0, C_NONE, 1'b0, 1'b0);
    applyStimulus("run_unstall", 1'b1, mkInstr(OP_CMP, 6'h0), 4'h0, 1'b0, 1'b1, C_FW, 1'b0, 1'b0);

    // HALT: halted from cycle 1, ready low for 20 cycles despite valid input
    applyStimulus("halt", 1'b1, mkInstr(OP_HALT, 6'h0), 4'h0, 1'b0, 1'b1, C_NONE, 1'b0, 1'b1);
    for (int i = 1; i <= 20; i++)
      applyStimulus($sformatf("halt_hold%0d", i), 1'b1, mkInstr(OP_LW, 6'h0), 4'h0, 1'b0, 1'b0, C_NONE, 1'b0, 1'b1);

    // Reset pulse mid-cycle: halted drops at once, then accept resumes
    @(negedge clk);
    checkOutput();
    instr_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkEq("halt_rst halted", {15'b0, halted},        16'h0);
    checkEq("halt_rst ctrl",   {5'b0, observedCtrl()}, 16'h0);
    checkEq("halt_rst ready",  {15'b0, instr_ready},   16'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkEq("halt_rst release ready", {15'b0, instr_ready}, 16'h1);
    scoreboard.delete();
    pushExp("halt_rst_idle", C_NONE, 1'b0, 1'b0);
    applyStimulus("resume_lw", 1'b1, mkInstr(OP_LW, 6'h0), 4'h0, 1'b0, 1'b1, C_MR | C_MTR | C_RW | C_DB, 1'b0, 1'b0);
    idle("resume_after");
    @(negedge clk);
    checkOutput();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/musa_control_unit.md
MUSA_CONTROL_UNIT -- requirements
Module: musa_control_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, instruction width.
REQ-002 SHALL have parameter MULDIV_LAT, default 4, total occupancy cycles of MULT/DIV (legal range 2..15).
REQ-003 SHALL have port clk  in  1  single processor clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port instr_valid  in  1  fetch presents an instruction.
REQ-006 SHALL have port instruction  in  DATA_WIDTH  opcode [31:26], funct [5:0], branch mask [3:0].
REQ-007 SHALL have port flags  in  4  ALU status flags for BRFL.
REQ-008 SHALL have port stall_in  in  1  downstream hold request.
REQ-009 SHALL have port instr_ready  out  1  instruction accepted this cycle when high with instr_valid.
REQ-010 SHALL have ports reg_dst, mem_read, mem_to_reg, mem_write, reg_write, data_a_s, data_b_s, pc_src, pop, push, flag_we  out  1 each  registered datapath controls.
REQ-011 SHALL have ports halted  out  1  core stopped; illegal  out  1  one-cycle pulse on undecodable opcode.

Function
REQ-012 SHALL accept an instruction on a rising edge where instr_valid and instr_ready are both high; instr_ready = state RUN and not stall_in.
REQ-013 SHALL drive decoded controls from an output register exactly 1 cycle after acceptance, each asserted for one cycle only; with no acceptance, all controls SHALL be 0 next cycle.
REQ-014 SHALL decode per opcode constants of the shared opcode definitions: LW -> mem_read, mem_to_reg, reg_write, data_b_s; SW -> mem_write, data_b_s; ADDI/SUBI/ANDI/ORI -> reg_write, data_b_s; R_TYPE -> reg_dst, reg_write; CMP -> flag_we; JPC -> pc_src; JR -> pc_src, data_a_s; CALL -> pc_src, data_a_s, push; RET -> pc_src, pop; BRFL -> pc_src = |(flags & instruction[3:0]) sampled at acceptance; HALT -> no controls.
REQ-015 SHALL implement FSM states RUN, MULDIV, HALT; reset state RUN.
REQ-016 SHALL, on accepting R_TYPE with funct MULT or DIV, issue reg_dst and reg_write 1 cycle later and enter MULDIV for MULDIV_LAT-1 cycles with instr_ready low, then return to RUN.
REQ-017 SHALL freeze the MULDIV down-counter while stall_in is high.
REQ-018 SHALL, on accepting HALT, enter HALT: halted=1, instr_ready=0, all controls 0, until reset.
REQ-019 SHALL, on unknown opcode, emit no controls and pulse illegal 1 cycle after acceptance; FSM stays RUN.
REQ-020 SHALL, while stall_in is high in RUN, accept nothing and hold the output register at 0 after the in-flight pulse completes.

Reset
REQ-021 SHALL on rst high, asynchronously clear all controls, illegal, halted, the counter, and force RUN; instr_ready reflects stall_in only after rst deasserts.
REQ-022 SHALL abort MULDIV or HALT immediately on reset with no residual control pulse.

Configuration
REQ-023 SHALL honour macro MUSA_STACK_EN: defined -> CALL/RET decode per REQ-014; undefined -> push and pop tied 0, CALL and RET treated as illegal per REQ-019.

Verification
REQ-024 SHALL cover: LW accepted at cycle 0 -> cycle 1 mem_read=reg_write=mem_to_reg=data_b_s=1, cycle 2 all 0.
REQ-025 SHALL cover: MULT with MULDIV_LAT=4 at cycle 0 -> reg_dst=reg_write=1 cycle 1, instr_ready=0 cycles 1-3, next instruction accepted cycle 4.
REQ-026 SHALL cover: BRFL mask 4'b0010 with flags 4'b0010 -> pc_src=1 next cycle; flags 4'b0101 -> pc_src=0.
REQ-027 SHALL cover: HALT accepted -> halted=1 from cycle 1, instr_ready=0 for 20 cycles; rst pulse -> halted=0 same cycle, accept resumes.
REQ-028 SHALL cover: stall_in high 3 cycles during MULDIV -> ready returns 3 cycles later than REQ-025 (cycle 7).
REQ-029 SHALL cover: CALL with MUSA_STACK_EN defined -> push=pc_src=1; undefined -> push=0, illegal=1 for one cycle.
